// File: rtl/matmul_stream_engine_if.sv
// Element stream bundle for the matmul engine.
// in_*: operand stream into the engine; out_*: result stream out of it.
interface matmul_stream_engine_if #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic              out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/matmul_stream_engine.sv
// Streamed n x n matrix multiplier: loads A then B row-major, one MAC/cycle, drains C.
// Ports: clk, reset (async, high), start/order/signed_mode job request,
// strm (element streams), busy, done pulse, err pulse on rejected start.
module matmul_stream_engine #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int OUT_W  = 32,
  parameter int N_MAX  = 16,
  parameter int SAT    = 1,
  parameter int ORD_W  = $clog2(N_MAX) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [ORD_W-1:0] order,
  input  logic             signed_mode,
  matmul_stream_engine_if.slave strm,
  output logic             busy,
  output logic             done,
  output logic             err
);
  localparam int DEPTH = N_MAX * N_MAX;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW    = 2 * ORD_W;

  localparam logic [ACC_W-1:0] SMAX =
    (ACC_W'(1) << (OUT_W - 1)) - ACC_W'(1);
  localparam logic [ACC_W-1:0] SMIN = ~SMAX;
  localparam logic [ACC_W-1:0] UMAX =
    (ACC_W'(1) << OUT_W) - ACC_W'(1);

  typedef enum logic [2:0] {
    IDLE, LOAD_A, LOAD_B, COMPUTE, DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [ORD_W-1:0]  n_q, nm1;
  logic              sgn_q;
  logic [AW-1:0]     idx_q;
  logic [ORD_W-1:0]  i_q, j_q, k_q;
  logic [ACC_W-1:0]  acc_q;
  logic              done_q, err_q;

  logic [DATA_W-1:0] a_mem [DEPTH];
  logic [DATA_W-1:0] b_mem [DEPTH];
  logic [OUT_W-1:0]  c_mem [DEPTH];

  logic              ord_ok, idx_last, mac_last, k_last;
  logic              in_fire, out_fire;
  logic [PW-1:0]     n_ext, nsq_m1;
  logic [DATA_W-1:0] a_op, b_op;
  logic [2*DATA_W-1:0] a_x, b_x, prod;
  logic [ACC_W-1:0]  prod_ext, acc_sum;
  logic [OUT_W-1:0]  c_wr;

  // Row-major address r*n + c.
  function automatic logic [AW-1:0] rm(
    input logic [ORD_W-1:0] r,
    input logic [ORD_W-1:0] c,
    input logic [ORD_W-1:0] nn
  );
    return AW'({{ORD_W{1'b0}}, r} * {{ORD_W{1'b0}}, nn}
             + {{ORD_W{1'b0}}, c});
  endfunction

  assign ord_ok   = (order != '0) && (order <= ORD_W'(N_MAX));
  assign nm1      = n_q - ORD_W'(1);
  assign n_ext    = {{ORD_W{1'b0}}, n_q};
  assign nsq_m1   = n_ext * n_ext - PW'(1);
  assign idx_last = ({{(PW-AW){1'b0}}, idx_q} == nsq_m1);
  assign k_last   = (k_q == nm1);
  assign mac_last = k_last && (j_q == nm1) && (i_q == nm1);

  assign strm.in_ready  = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign strm.out_valid = (state_q == DRAIN);
  assign strm.out_last  = strm.out_valid && idx_last;
  assign strm.out_data  = strm.out_valid ? c_mem[idx_q] : '0;

  assign in_fire  = strm.in_valid && strm.in_ready;
  assign out_fire = strm.out_valid && strm.out_ready;

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign err  = err_q;

  // Operands are extended to 2*DATA_W first, so the low half of the
  // product is correct for both signed and unsigned modes.
  always_comb begin
    a_op = a_mem[rm(i_q, k_q, n_q)];
    b_op = b_mem[rm(k_q, j_q, n_q)];
    if (sgn_q) begin
      a_x = {{DATA_W{a_op[DATA_W-1]}}, a_op};
      b_x = {{DATA_W{b_op[DATA_W-1]}}, b_op};
    end else begin
      a_x = {{DATA_W{1'b0}}, a_op};
      b_x = {{DATA_W{1'b0}}, b_op};
    end
    prod = a_x * b_x;
    if (sgn_q) prod_ext = ACC_W'($signed(prod));
    else       prod_ext = ACC_W'(prod);
    acc_sum = ((k_q == '0) ? '0 : acc_q) + prod_ext;
  end

  always_comb begin
    c_wr = acc_sum[OUT_W-1:0];
    if (SAT != 0) begin
      if (sgn_q) begin
        if ($signed(acc_sum) > $signed(SMAX))
          c_wr = SMAX[OUT_W-1:0];
        else if ($signed(acc_sum) < $signed(SMIN))
          c_wr = SMIN[OUT_W-1:0];
      end else if (acc_sum > UMAX) begin
        c_wr = UMAX[OUT_W-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && ord_ok) state_d = LOAD_A;
      LOAD_A:  if (in_fire && idx_last) state_d = LOAD_B;
      LOAD_B:  if (in_fire && idx_last) state_d = COMPUTE;
      COMPUTE: if (mac_last) state_d = DRAIN;
      DRAIN:   if (out_fire && idx_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      n_q     <= ORD_W'(1);
      sgn_q   <= 1'b0;
      idx_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= out_fire && idx_last;
      err_q   <= (state_q == IDLE) && start && !ord_ok;
      case (state_q)
        IDLE: begin
          if (start && ord_ok) begin
            n_q   <= order;
            sgn_q <= signed_mode;
            idx_q <= '0;
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
          end
        end
        LOAD_A, LOAD_B: begin
          if (in_fire)
            idx_q <= idx_last ? '0 : idx_q + AW'(1);
        end
        COMPUTE: begin
          acc_q <= acc_sum;
          if (k_last) begin
            k_q <= '0;
            if (j_q == nm1) begin
              j_q <= '0;
              i_q <= i_q + ORD_W'(1);
            end else begin
              j_q <= j_q + ORD_W'(1);
            end
          end else begin
            k_q <= k_q + ORD_W'(1);
          end
        end
        DRAIN: begin
          if (out_fire)
            idx_q <= idx_last ? '0 : idx_q + AW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire && (state_q == LOAD_A)) a_mem[idx_q] <= strm.in_data;
    if (in_fire && (state_q == LOAD_B)) b_mem[idx_q] <= strm.in_data;
    if ((state_q == COMPUTE) && k_last)
      c_mem[rm(i_q, j_q, n_q)] <= c_wr;
  end
endmodule

// File: tb/tb_matmul_stream_engine.sv
// Bench for matmul_stream_engine: three instances (16-bit, 8-bit sat, 8-bit trunc)
// share one stimulus stream; vectors table plus hand-written corner sequences.
module tb_matmul_stream_engine;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  order = '0;
  logic        signed_mode = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        busy0, done0, err0;
  logic        busy_s, done_s, err_s;
  logic        busy_t, done_t, err_t;
  int          cyc = 0;
  int          errs = 0;
  int          checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  matmul_stream_engine_if #(.DATA_W(16), .OUT_W(32)) if0 ();
  matmul_stream_engine_if #(.DATA_W(8),  .OUT_W(8))  ifs ();
  matmul_stream_engine_if #(.DATA_W(8),  .OUT_W(8))  ift ();

  assign if0.in_valid  = in_valid;
  assign if0.in_data   = in_data;
  assign if0.out_ready = out_ready;
  assign ifs.in_valid  = in_valid;
  assign ifs.in_data   = in_data[7:0];
  assign ifs.out_ready = out_ready;
  assign ift.in_valid  = in_valid;
  assign ift.in_data   = in_data[7:0];
  assign ift.out_ready = out_ready;

  matmul_stream_engine u0 (
    .clk(clk), .reset(reset), .start(start), .order(order),
    .signed_mode(signed_mode), .strm(if0),
    .busy(busy0), .done(done0), .err(err0)
  );

  matmul_stream_engine #(
    .DATA_W(8), .ACC_W(20), .OUT_W(8), .N_MAX(16), .SAT(1)
  ) us (
    .clk(clk), .reset(reset), .start(start), .order(order),
    .signed_mode(signed_mode), .strm(ifs),
    .busy(busy_s), .done(done_s), .err(err_s)
  );

  matmul_stream_engine #(
    .DATA_W(8), .ACC_W(20), .OUT_W(8), .N_MAX(16), .SAT(0)
  ) ut (
    .clk(clk), .reset(reset), .start(start), .order(order),
    .signed_mode(signed_mode), .strm(ift),
    .busy(busy_t), .done(done_t), .err(err_t)
  );

  typedef struct packed {
    logic [3:0]        n;
    logic              sgn;
    logic              gaps;
    logic [8:0][15:0]  a;
    logic [8:0][15:0]  b;
    logic [8:0][31:0]  e0;
    logic [8:0][7:0]   es;
    logic [8:0][7:0]   et;
  } vec_t;

  vec_t tv [5];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic feed(input logic [15:0] d);
    int t;
    in_valid = 1'b1;
    in_data  = d;
    t = 0;
    while (!if0.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("feed_accept", t < 50, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input int v);
    int n, nn, hs_cyc, first_cyc;
    n  = int'(tv[v].n);
    nn = n * n;
    hs_cyc = -1;
    first_cyc = -1;
    @(negedge clk);
    start = 1'b1;
    order = 5'(n);
    signed_mode = tv[v].sgn;
    @(negedge clk);
    start = 1'b0;
    order = '0;
    chk("busy_after_start", busy0, 1);
    fork
      begin
        int tmo;
        for (int e = 0; e < 2 * nn; e++) begin
          if (tv[v].gaps)
            repeat ($urandom_range(0, 2)) begin
              in_valid = 1'b0;
              in_data  = 16'hBEEF;
              @(negedge clk);
            end
          in_valid = 1'b1;
          in_data  = (e < nn) ? tv[v].a[e] : tv[v].b[e - nn];
          tmo = 0;
          while (!if0.in_ready && tmo < 50) begin
            @(negedge clk);
            tmo++;
          end
          if (tmo >= 50) chk("in_ready_timeout", 0, 1);
          hs_cyc = cyc;
          @(negedge clk);
        end
        in_valid = tv[v].gaps;
        in_data  = 16'hDEAD;
      end
      begin
        int k, lim;
        logic stalled;
        logic [31:0] hd;
        k = 0;
        lim = 0;
        stalled = 1'b0;
        hd = '0;
        while (k < nn && lim < 3000) begin
          @(negedge clk);
          lim++;
          if (stalled) chk("stall_hold", if0.out_data, hd);
          if (if0.out_valid) begin
            if (first_cyc < 0) begin
              first_cyc = cyc;
              chk("first_valid_latency", cyc - hs_cyc, n * n * n + 1);
            end
            out_ready = tv[v].gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (out_ready) begin
              chk("out_data16", if0.out_data, tv[v].e0[k]);
              chk("out_last16", if0.out_last, k == nn - 1);
              chk("out_data8_sat", ifs.out_data, tv[v].es[k]);
              chk("out_data8_trunc", ift.out_data, tv[v].et[k]);
              k++;
              stalled = 1'b0;
            end else begin
              stalled = 1'b1;
              hd = if0.out_data;
            end
          end else begin
            out_ready = tv[v].gaps ? ($urandom_range(0, 1) == 1) : 1'b0;
          end
        end
        chk("out_count", k, nn);
        @(negedge clk);
        out_ready = 1'b0;
        chk("done_pulse", done0, 1);
        chk("done_pulse8", done_s, 1);
        chk("valid_drop", if0.out_valid, 0);
        chk("idle_after_done", busy0, 0);
        @(negedge clk);
        chk("done_clear", done0, 0);
      end
    join
    in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '0;
    tv[0].n = 4'd2;
    tv[0].sgn = 1'b1;
    for (int e = 0; e < 4; e++) begin
      tv[0].a[e] = 16'(e + 1);
      tv[0].b[e] = 16'(e + 5);
    end
    tv[0].e0[0] = 32'd19; tv[0].e0[1] = 32'd22;
    tv[0].e0[2] = 32'd43; tv[0].e0[3] = 32'd50;
    for (int e = 0; e < 4; e++) begin
      tv[0].es[e] = tv[0].e0[e][7:0];
      tv[0].et[e] = tv[0].e0[e][7:0];
    end

    tv[1] = '0;
    tv[1].n = 4'd3;
    tv[1].sgn = 1'b1;
    tv[1].gaps = 1'b1;
    for (int e = 0; e < 9; e++) begin
      tv[1].a[e]  = (e % 4 == 0) ? 16'd1 : 16'd0;
      tv[1].b[e]  = 16'(e + 1);
      tv[1].e0[e] = 32'(e + 1);
      tv[1].es[e] = 8'(e + 1);
      tv[1].et[e] = 8'(e + 1);
    end

    tv[2] = '0;
    tv[2].n = 4'd2;
    tv[2].sgn = 1'b1;
    tv[3] = '0;
    tv[3].n = 4'd2;
    tv[3].sgn = 1'b1;
    for (int e = 0; e < 4; e++) begin
      tv[2].a[e] = 16'd127;   tv[2].b[e] = 16'd127;
      tv[2].e0[e] = 32'd32258;
      tv[2].es[e] = 8'd127;   tv[2].et[e] = 8'h02;
      tv[3].a[e] = 16'd127;   tv[3].b[e] = 16'hFF80;
      tv[3].e0[e] = 32'hFFFF8100;
      tv[3].es[e] = 8'h80;    tv[3].et[e] = 8'h00;
    end

    tv[4] = '0;
    tv[4].n = 4'd1;
    tv[4].a[0] = 16'h00FF;
    tv[4].b[0] = 16'h00FF;
    tv[4].e0[0] = 32'd65025;
    tv[4].es[0] = 8'hFF;
    tv[4].et[0] = 8'h01;

    #1;
    chk("rst_busy", busy0, 0);
    chk("rst_in_ready", if0.in_ready, 0);
    chk("rst_out_valid", if0.out_valid, 0);
    chk("rst_out_data", if0.out_data, 0);
    chk("rst_done_err", {done0, err0, if0.out_last}, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 5; v++) run_vec(v);

    // rejected orders
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      start = 1'b1;
      order = (r == 0) ? 5'd0 : 5'd17;
      @(negedge clk);
      start = 1'b0;
      order = '0;
      chk("err_pulse", err0, 1);
      chk("err_busy", busy0, 0);
      chk("err_in_ready", if0.in_ready, 0);
      @(negedge clk);
      chk("err_clear", err0, 0);
    end

    // start while busy is ignored: n stays 1, result 3*5
    @(negedge clk);
    start = 1'b1;
    order = 5'd1;
    signed_mode = 1'b1;
    @(negedge clk);
    start = 1'b1;
    order = 5'd0;
    @(negedge clk);
    chk("busy_start_no_err", err0, 0);
    order = 5'd2;
    @(negedge clk);
    start = 1'b0;
    order = '0;
    chk("busy_start_busy", busy0, 1);
    feed(16'd3);
    feed(16'd5);
    begin
      int t;
      t = 0;
      while (!if0.out_valid && t < 20) begin
        @(negedge clk);
        t++;
      end
      chk("busy_start_result", if0.out_data, 32'd15);
      chk("busy_start_last", if0.out_last, 1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("busy_start_done", done0, 1);
    end

    // reset in the middle of an n=4 COMPUTE
    @(negedge clk);
    start = 1'b1;
    order = 5'd4;
    @(negedge clk);
    start = 1'b0;
    order = '0;
    for (int e = 0; e < 32; e++) feed(16'(e));
    repeat (30) @(negedge clk);
    chk("mid_busy", busy0, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_busy", busy0, 0);
    chk("abort_in_ready", if0.in_ready, 0);
    chk("abort_out_valid", if0.out_valid, 0);
    chk("abort_out_data", if0.out_data, 0);
    chk("abort_done_err_last", {done0, err0, if0.out_last}, 0);
    @(negedge clk);
    reset = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      out_ready = 1'b1;
      repeat (80) begin
        @(negedge clk);
        if (if0.out_valid || busy0) seen = 1'b1;
      end
      out_ready = 1'b0;
      chk("no_output_after_abort", seen, 0);
    end
    run_vec(0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
